// File: rtl/per_rx_fifo.sv
// Peripheral receive stage: 4-phase send/ack capture into a small FIFO drained by a valid/ready stream.
// Optional macro PER_RX_SYNC_EN adds a 2-flop synchronizer on per_send.
module per_rx_fifo #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                     per_clock,
    input  logic                     per_reset,
    input  logic                     per_send,
    input  logic [DATA_W-1:0]        in_per_dados,
    output logic                     per_ack,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         rx_total
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]         count_q, count_d;
    logic [CNT_W-1:0]    total_q, total_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                send_s;
    logic                push;
    logic                pop;
    logic                full;

`ifdef PER_RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge per_clock or posedge per_reset) begin
        if (per_reset) sync_q <= '0;
        else           sync_q <= {sync_q[0], per_send};
    end

    assign send_s = sync_q[1];
`else
    assign send_s = per_send;
`endif

    assign full = (count_q == FULL_CNT);

    // Push decision uses pre-edge occupancy, so a same-edge pop never frees room for it.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (send_s && !full) begin
                    push    = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!send_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        pop      = (count_q != '0) && out_ready;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        total_d  = push ? total_q + 1'b1  : total_q;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge per_clock or posedge per_reset) begin
        if (per_reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            total_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            total_q  <= total_d;
        end
    end

    always_ff @(posedge per_clock) begin
        if (push) mem_q[wr_ptr_q] <= in_per_dados;
    end

    assign per_ack    = (state_q == ACK);
    assign out_valid  = (count_q != '0);
    assign out_data   = mem_q[rd_ptr_q];
    assign fifo_count = count_q;
    assign rx_total   = total_q;

endmodule
